reg_write_sequencer: RTL and testbench

Command-driven initiator that writes the 16-bit registers of the datapath through their `E`/`FunSel`/`I` port.
- Accepts one write command per valid/ready handshake and expands it into the required beats on the selected register's port: two-beat low-then-high byte writes, or a single load, clear or byte-extend.
- After the beats, it reads the register back and reports a mismatch.
- Sits between the control unit / byte-wide bus and the register file.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/reg_write_sequencer.sv | 150 +++++++++++++++
 tb/tb_reg_write_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared between the datapath register file and
// the blocks that drive its E/FunSel/I port.
//   FS_*           3-bit register function selects
//   cmd_op_t       write-command opcode seen by reg_write_sequencer
//   seq_state_t    reg_write_sequencer FSM states
//   expected_value value a register must hold after a command completes
package alu_pkg;

  localparam logic [2:0] FS_DEC      = 3'b000;
  localparam logic [2:0] FS_INC      = 3'b001;
  localparam logic [2:0] FS_LOAD     = 3'b010;
  localparam logic [2:0] FS_CLR      = 3'b011;
  localparam logic [2:0] FS_CLRH_WRL = 3'b100;
  localparam logic [2:0] FS_WRL      = 3'b101;
  localparam logic [2:0] FS_WRH      = 3'b110;
  localparam logic [2:0] FS_SEXT     = 3'b111;

  typedef enum logic [1:0] {
    OP_WORD    = 2'd0,
    OP_BYTE_ZX = 2'd1,
    OP_BYTE_SX = 2'd2,
    OP_CLEAR   = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BEAT_LO = 2'd1,
    S_BEAT_HI = 2'd2,
    S_CHECK   = 2'd3
  } seq_state_t;

  function automatic logic [15:0] expected_value(cmd_op_t op, logic [15:0] data);
    logic [15:0] v;
    case (op)
      OP_WORD:    v = data;
      OP_BYTE_ZX: v = {8'h00, data[7:0]};
      OP_BYTE_SX: v = {{8{data[7]}}, data[7:0]};
      default:    v = 16'h0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/reg_write_sequencer.sv
// reg_write_sequencer: takes one write command per Cmd_Valid/Cmd_Ready
// handshake and plays it onto the selected register's E/FunSel/I port, then
// reads the register back through Q_All and flags a mismatch.
//   Clock, Reset            rising-edge clock, async active-low reset
//   Cmd_Valid/Ready         command handshake (Ready only in IDLE)
//   Cmd_Op/Sel/Data         opcode, target register index, write data
//   E/FunSel/I              register write port (E one-hot, Moore)
//   Q_All                   packed register outputs, reg k at [16k+15:16k]
//   Done/Mismatch/Err       completion pulse with read-back and bad-sel flags
module reg_write_sequencer
  import alu_pkg::*;
#(
  parameter int NUM_REGS  = 4,
  parameter bit BYTE_LANE = 1'b1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Cmd_Valid,
  output logic                   Cmd_Ready,
  input  logic [1:0]             Cmd_Op,
  input  logic [1:0]             Cmd_Sel,
  input  logic [15:0]            Cmd_Data,
  output logic [NUM_REGS-1:0]    E,
  output logic [2:0]             FunSel,
  output logic [15:0]            I,
  input  logic [16*NUM_REGS-1:0] Q_All,
  output logic                   Done,
  output logic                   Mismatch,
  output logic                   Err
);

  seq_state_t state, state_nxt;

  cmd_op_t     op_q;
  logic [1:0]  sel_q;
  logic [15:0] data_q;
  logic [15:0] exp_q;
  logic        err_q;

  logic                accept;
  logic                sel_bad;
  logic [NUM_REGS-1:0] sel_oh;
  logic [15:0]         rd_q;

  assign accept  = Cmd_Valid && (state == S_IDLE);
  assign sel_bad = int'(Cmd_Sel) >= NUM_REGS;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      op_q   <= OP_WORD;
      sel_q  <= 2'd0;
      data_q <= 16'h0000;
      exp_q  <= 16'h0000;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= cmd_op_t'(Cmd_Op);
        sel_q  <= Cmd_Sel;
        data_q <= Cmd_Data;
        exp_q  <= expected_value(cmd_op_t'(Cmd_Op), Cmd_Data);
        err_q  <= sel_bad;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (sel_bad)
            state_nxt = S_CHECK;
          else if (BYTE_LANE && (cmd_op_t'(Cmd_Op) == OP_WORD))
            state_nxt = S_BEAT_LO;
          else
            state_nxt = S_BEAT_HI;
        end
      end
      S_BEAT_LO: state_nxt = S_BEAT_HI;
      S_BEAT_HI: state_nxt = S_CHECK;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Decode the latched index against the real register count so an
  // out-of-range sel can never raise an E bit or alias another register.
  always_comb begin
    sel_oh = '0;
    rd_q   = 16'h0000;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (!err_q && (int'(sel_q) == k)) begin
        sel_oh[k] = 1'b1;
        rd_q      = Q_All[16*k +: 16];
      end
    end
  end

  always_comb begin
    Cmd_Ready = (state == S_IDLE);
    E         = '0;
    FunSel    = FS_DEC;
    I         = 16'h0000;
    Done      = 1'b0;
    Mismatch  = 1'b0;
    Err       = 1'b0;
    case (state)
      S_BEAT_LO: begin
        E      = sel_oh;
        FunSel = FS_WRL;
        I      = {8'h00, data_q[7:0]};
      end
      S_BEAT_HI: begin
        E = sel_oh;
        case (op_q)
          OP_WORD: begin
            if (BYTE_LANE) begin
              FunSel = FS_WRH;
              I      = {8'h00, data_q[15:8]};
            end else begin
              FunSel = FS_LOAD;
              I      = data_q;
            end
          end
          OP_BYTE_ZX: begin
            FunSel = FS_CLRH_WRL;
            I      = {8'h00, data_q[7:0]};
          end
          OP_BYTE_SX: begin
            FunSel = FS_SEXT;
            I      = {8'h00, data_q[7:0]};
          end
          default: begin
            FunSel = FS_CLR;
            I      = 16'h0000;
          end
        endcase
      end
      S_CHECK: begin
        // Beats were captured at the previous edges, so Q is already post-write.
        Done     = 1'b1;
        Err      = err_q;
        Mismatch = !err_q && (rd_q != exp_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_write_sequencer.sv
module tb_reg_write_sequencer;
  import alu_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  // shared command fields, per-DUT valid
  logic [1:0]  op, sel;
  logic [15:0] data;
  logic        va, vb;

  // DUT A: 4 regs, two-beat words
  logic        rdy_a, done_a, mis_a, err_a;
  logic [3:0]  e_a;
  logic [2:0]  fs_a;
  logic [15:0] i_a;
  logic [63:0] q_a;
  // DUT B: 3 regs, single-beat words
  logic        rdy_b, done_b, mis_b, err_b;
  logic [2:0]  e_b;
  logic [2:0]  fs_b;
  logic [15:0] i_b;
  logic [47:0] q_b;

  reg_write_sequencer #(.NUM_REGS(4), .BYTE_LANE(1'b1)) dut_a (
    .Clock(Clock), .Reset(Reset), .Cmd_Valid(va), .Cmd_Ready(rdy_a),
    .Cmd_Op(op), .Cmd_Sel(sel), .Cmd_Data(data), .E(e_a), .FunSel(fs_a),
    .I(i_a), .Q_All(q_a), .Done(done_a), .Mismatch(mis_a), .Err(err_a));

  reg_write_sequencer #(.NUM_REGS(3), .BYTE_LANE(1'b0)) dut_b (
    .Clock(Clock), .Reset(Reset), .Cmd_Valid(vb), .Cmd_Ready(rdy_b),
    .Cmd_Op(op), .Cmd_Sel(sel), .Cmd_Data(data), .E(e_b), .FunSel(fs_b),
    .I(i_b), .Q_All(q_b), .Done(done_b), .Mismatch(mis_b), .Err(err_b));

  // register bank models (not cleared by Reset)
  logic [15:0] ra [4];
  logic [15:0] rb [3];
  logic        pre_en = 1'b0;
  int          pre_k = 0;
  logic [15:0] pre_v = '0;
  logic        stuck = 1'b0;

  function automatic logic [15:0] reg_next(logic [2:0] fs, logic [15:0] q, logic [15:0] d);
    case (fs)
      3'b000:  return q - 16'd1;
      3'b001:  return q + 16'd1;
      3'b010:  return d;
      3'b011:  return 16'h0000;
      3'b100:  return {8'h00, d[7:0]};
      3'b101:  return {q[15:8], d[7:0]};
      3'b110:  return {d[7:0], q[7:0]};
      default: return {{8{d[7]}}, d[7:0]};
    endcase
  endfunction

  always @(posedge Clock) begin
    for (int k = 0; k < 4; k++) begin
      if (pre_en && pre_k == k) ra[k] <= pre_v;
      else if (e_a[k] && !stuck) ra[k] <= reg_next(fs_a, ra[k], i_a);
    end
    for (int k = 0; k < 3; k++) begin
      if (pre_en && pre_k == k) rb[k] <= pre_v;
      else if (e_b[k]) rb[k] <= reg_next(fs_b, rb[k], i_b);
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) q_a[16*k +: 16] = ra[k];
    for (int k = 0; k < 3; k++) q_b[16*k +: 16] = rb[k];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic preload(input int k, input logic [15:0] v);
    @(negedge Clock);
    pre_en = 1'b1; pre_k = k; pre_v = v;
    step();
    pre_en = 1'b0;
  endtask

  // present a command at the negedge, accept at the next posedge (T), return at T+1
  task automatic issue(input bit to_b, input logic [1:0] o, input logic [1:0] s, input logic [15:0] d);
    @(negedge Clock);
    op = o; sel = s; data = d;
    if (to_b) vb = 1'b1; else va = 1'b1;
    step();
    va = 1'b0; vb = 1'b0;
    op = 2'd0; sel = 2'd0; data = 16'h0000;
  endtask

  initial begin
    op = '0; sel = '0; data = '0; va = 1'b0; vb = 1'b0;
    for (int k = 0; k < 4; k++) ra[k] = 16'h0000;
    for (int k = 0; k < 3; k++) rb[k] = 16'h0000;

    // reset state
    #12;
    chk("rst_ready", rdy_a, 1);
    chk("rst_E", e_a, 0);
    chk("rst_fs", fs_a, 0);
    chk("rst_I", i_a, 0);
    chk("rst_flags", {done_a, mis_a, err_a, done_b}, 0);
    @(negedge Clock);
    Reset = 1'b1;
    step();
    chk("idle_ready", {rdy_a, rdy_b}, 2'b11);

    // two-beat WORD sel=1
    issue(0, OP_WORD, 2'd1, 16'hA55A);
    chk("w_lo_E", e_a, 4'b0010);
    chk("w_lo_fs", fs_a, 3'b101);
    chk("w_lo_I", i_a, 16'h005A);
    chk("w_lo_busy", {rdy_a, done_a}, 2'b00);
    step();
    chk("w_hi_E", e_a, 4'b0010);
    chk("w_hi_fs", fs_a, 3'b110);
    chk("w_hi_I", i_a, 16'h00A5);
    step();
    chk("w_done", {done_a, mis_a, err_a, e_a}, {3'b100, 4'b0000});
    chk("w_reg", ra[1], 16'hA55A);
    step();
    chk("w_after", {rdy_a, done_a}, 2'b10);

    // BYTE_SX sel=0
    issue(0, OP_BYTE_SX, 2'd0, 16'h0080);
    chk("sx_E", e_a, 4'b0001);
    chk("sx_fs", fs_a, 3'b111);
    chk("sx_I", i_a, 16'h0080);
    step();
    chk("sx_done", {done_a, mis_a, err_a}, 3'b100);
    chk("sx_reg", ra[0], 16'hFF80);

    // BYTE_ZX over 0xFFFF, sel=3
    preload(3, 16'hFFFF);
    issue(0, OP_BYTE_ZX, 2'd3, 16'h1234);
    chk("zx_E", e_a, 4'b1000);
    chk("zx_fs", fs_a, 3'b100);
    chk("zx_I", i_a, 16'h0034);
    step();
    chk("zx_done", {done_a, mis_a}, 2'b10);
    chk("zx_reg", ra[3], 16'h0034);

    // stuck register: read-back must disagree
    preload(2, 16'h1111);
    stuck = 1'b1;
    issue(0, OP_WORD, 2'd2, 16'h2222);
    step();
    step();
    chk("stuck_done", {done_a, mis_a, err_a}, 3'b110);
    stuck = 1'b0;
    step();

    // NUM_REGS=3, illegal sel
    issue(1, OP_WORD, 2'd3, 16'hDEAD);
    chk("bad_done", {done_b, err_b, mis_b, e_b}, {3'b110, 3'b000});
    step();
    chk("bad_after", {rdy_b, done_b, e_b}, {2'b10, 3'b000});

    // single-beat WORD on NUM_REGS=3 instance
    issue(1, OP_WORD, 2'd1, 16'hC3C3);
    chk("ld_beat", {e_b, fs_b, i_b}, {3'b010, 3'b010, 16'hC3C3});
    step();
    chk("ld_done", {done_b, mis_b, err_b}, 3'b100);
    chk("ld_reg", rb[1], 16'hC3C3);
    step();

    // reset during BEAT_HI of WORD 0xBEEF
    preload(0, 16'h0000);
    issue(0, OP_WORD, 2'd0, 16'hBEEF);
    step();
    chk("ab_hi", {e_a, fs_a}, {4'b0001, 3'b110});
    #1 Reset = 1'b0;
    #1;
    chk("ab_E", {e_a, done_a}, {4'b0000, 1'b0});
    step();
    chk("ab_nodone", done_a, 0);
    @(negedge Clock);
    Reset = 1'b1;
    step();
    chk("ab_ready", {rdy_a, done_a}, 2'b10);
    chk("ab_reg", ra[0], 16'h00EF);

    // next CLEAR completes normally
    issue(0, OP_CLEAR, 2'd0, 16'h5555);
    chk("clr_beat", {e_a, fs_a, i_a}, {4'b0001, 3'b011, 16'h0000});
    step();
    chk("clr_done", {done_a, mis_a, err_a}, 3'b100);
    chk("clr_reg", ra[0], 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // at most one E bit, never during IDLE/CHECK-like cycles (Ready or Done high)
  always @(negedge Clock) begin
    if (Reset && ($countones(e_a) > 1 || ((rdy_a || done_a) && e_a != 0)))
      chk("onehot_a", e_a, 0);
    if (Reset && ($countones(e_b) > 1 || ((rdy_b || done_b) && e_b != 0)))
      chk("onehot_b", e_b, 0);
  end

endmodule
